pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the MIPS datapath fetch stage. It combines the PC register, the PC+STEP incrementer, the next-PC select (sequential, branch, jump, register jump, return) and a small circular return-address stack (RAS) that predicts return targets. The instruction memory address and the link value for `jal`-style writes come from this block. It replaces the free-standing PC+4 adder.

## Interface
- `WIDTH`, 32: address width in bits.
- `STEP`, 4: sequential increment in bytes; must be a power of two ≥ 1. Targets are aligned to it.
- `RESET_VECTOR`, 0: PC value after reset; must be STEP-aligned.
- `RAS_DEPTH`, 4: return-address stack entries; ≥ 2, power of two.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `stall`  in  1  hold the PC and ignore all other control this cycle.
- `branch_taken`  in  1  take a PC-relative branch.
- `branch_offset`  in  WIDTH  signed byte offset, added to PC+STEP.
- `jump`  in  1  absolute jump to `jump_target`.
- `jump_target`  in  WIDTH  absolute jump address.
- `call`  in  1  push PC+STEP onto the RAS. Qualifies `jump` or `jr`; on its own it only pushes.
- `jr`  in  1  register jump to `reg_target`.
- `ret`  in  1  return: target is the RAS top, or `reg_target` if the RAS is empty.
- `reg_target`  in  WIDTH  register-file operand for `jr` and the `ret` fallback.
- `pc`  out  WIDTH  current PC (registered).
- `pc_plus_step`  out  WIDTH  `pc + STEP`, combinational; also the link value.
- `misaligned`  out  1  registered one-cycle pulse: the last loaded target had nonzero low bits.
- `ret_from_ras`  out  1  registered one-cycle pulse: the last `ret` used a RAS entry.
- `ras_empty`  out  1  RAS count is 0.
- `ras_full`  out  1  RAS count equals RAS_DEPTH.

## Operation
- All adds are modulo 2^WIDTH. No overflow flag. `pc_plus_step` wraps 0xFFFFFFFC→0x00000000 (default parameters).
- Branch target = `pc_plus_step + branch_offset`.
- Next-PC priority when `stall`=0:
  1. `ret`
  2. `jr`
  3. `jump`
  4. `branch_taken`
  5. `pc_plus_step`
- Every selected target is loaded as `target & ~(STEP-1)`. `misaligned` is set next cycle iff the discarded bits were nonzero; otherwise it is cleared.
- RAS state:
  - Circular buffer with top pointer and count (0..RAS_DEPTH).
  - Push: write `pc_plus_step` at top+1, advance top. Count saturates at RAS_DEPTH. When full, the oldest entry is silently overwritten.
  - Pop: read entry at top, retreat top, decrement count. If empty, no pop occurs, `reg_target` is used and `ret_from_ras`=0.
  - `call` and `ret` in the same cycle: the return target is the current top. The top entry is then overwritten in place with `pc_plus_step`. Pointer and count are unchanged. If the RAS was empty, this acts as a push and the target is `reg_target`.
- `stall`=1: `pc`, RAS contents, pointer and count all hold. `misaligned` and `ret_from_ras` clear to 0.
- `ras_empty` and `ras_full` are decoded from the registered count.

## Timing
- Single clock domain. All state updates on the rising edge of `clk`.
- Redirect latency: a control input sampled at edge N makes `pc` equal the new value after edge N. There are no bubbles inside this block.
- `pc_plus_step` follows `pc` combinationally in the same cycle.
- RAS reads use the pre-edge top. A value pushed at edge N can be popped at edge N+1.
- Reset (`rst_n`=0, any time, including mid-redirect or during a stall), asynchronous:
  - `pc`=RESET_VECTOR
  - count=0, top pointer=0, `ras_empty`=1, `ras_full`=0
  - `misaligned`=0, `ret_from_ras`=0
  - RAS data contents are don't-care.
- Release: the first update happens on the first rising edge with `rst_n`=1.

## Test plan
- Reset then free-run for 3 cycles with all controls at 0 → `pc` = 0, 4, 8, 12; `pc_plus_step` = 4, 8, 12, 16.
- At pc=0x10, `branch_taken`=1 with offset 0xFFFFFFF8 → pc=0x0C. Next cycle, `jump`=1 and `branch_taken`=1 with target 0x100 → pc=0x100 (jump wins).
- Call/return sequence:
  - `jump`+`call` at pc=0x20 to 0x200 → RAS holds 0x24, `ras_empty`=0.
  - `ret` at 0x204 → pc=0x24, `ret_from_ras`=1, `ras_empty`=1.
  - A second `ret` with `reg_target`=0x80 → pc=0x80, `ret_from_ras`=0.
- RAS overflow with RAS_DEPTH=4:
  - 5 calls pushing 0x104, 0x204, 0x304, 0x404, 0x504 → `ras_full`=1.
  - 4 rets return 0x504, 0x404, 0x304, 0x204, then `ras_empty`=1.
- `jr` to 0x1003 → pc=0x1000 and `misaligned`=1 for exactly one cycle. With `stall` held for 3 cycles, `pc` stays 0x1000 and `misaligned`=0.
- Assert `rst_n` low mid-cycle during `call` with the RAS holding 2 entries → `pc`=RESET_VECTOR and `ras_empty`=1 immediately, without waiting for a clock edge. A subsequent `ret` uses `reg_target`.

Source files
------------

// File: rtl/pc_unit.sv
// Purpose : fetch-stage program counter with next-PC select and return-address stack.
// Latency : a redirect sampled at edge N is visible on o_pc after edge N; o_pc_plus_step is combinational.
// Backpr. : i_stall freezes PC and RAS and clears the status pulses; there is no other flow control.
//
// Ports:
//   i_clk, i_rst_n               clock, asynchronous active-low reset
//   i_stall                      hold everything this cycle
//   i_branch_taken/_offset       PC-relative branch, offset added to pc+STEP
//   i_jump/_target               absolute jump
//   i_call                       push pc+STEP onto the RAS (qualifies jump/jr, or pushes alone)
//   i_jr, i_ret, i_reg_target    register jump; return (RAS top, or i_reg_target when empty)
//   o_pc, o_pc_plus_step         current PC and link value
//   o_misaligned, o_ret_from_ras one-cycle status pulses about the last load
//   o_ras_empty, o_ras_full      RAS occupancy flags
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter int               STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall,
  input  logic             i_branch_taken,
  input  logic [WIDTH-1:0] i_branch_offset,
  input  logic             i_jump,
  input  logic [WIDTH-1:0] i_jump_target,
  input  logic             i_call,
  input  logic             i_jr,
  input  logic             i_ret,
  input  logic [WIDTH-1:0] i_reg_target,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_pc_plus_step,
  output logic             o_misaligned,
  output logic             o_ret_from_ras,
  output logic             o_ras_empty,
  output logic             o_ras_full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
  // Bits below the STEP alignment; these are stripped from every loaded target.
  localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(STEP - 1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(RAS_DEPTH);

  // Architectural state
  logic [WIDTH-1:0] r_pc;
  logic [PW-1:0]    r_top;
  logic [CW-1:0]    r_cnt;
  logic             r_misaligned;
  logic             r_ret_from_ras;
  logic [WIDTH-1:0] r_ras [RAS_DEPTH];

  // Next-state wires
  logic [WIDTH-1:0] w_pc_plus_step;
  logic [WIDTH-1:0] w_branch_target;
  logic [WIDTH-1:0] w_target;
  logic             w_ras_has;
  logic             w_ras_used;
  logic             w_replace;
  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_top_inc;
  logic [PW-1:0]    w_top_dec;
  logic [PW-1:0]    w_top_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [PW-1:0]    w_wr_idx;

  assign w_pc_plus_step  = r_pc + STEP_W;
  assign w_branch_target = w_pc_plus_step + i_branch_offset;
  assign w_ras_has       = (r_cnt != '0);
  assign w_top_inc       = r_top + PW'(1);
  assign w_top_dec       = r_top - PW'(1);

  // Next-PC select, highest priority first: ret, jr, jump, branch, sequential.
  always_comb begin
    w_target   = w_pc_plus_step;
    w_ras_used = 1'b0;
    if (i_ret) begin
      if (w_ras_has) begin
        w_target   = r_ras[r_top];
        w_ras_used = 1'b1;
      end else begin
        w_target   = i_reg_target;
      end
    end else if (i_jr) begin
      w_target = i_reg_target;
    end else if (i_jump) begin
      w_target = i_jump_target;
    end else if (i_branch_taken) begin
      w_target = w_branch_target;
    end
  end

  // RAS operation decode.
  // call+ret with a live entry swaps the top in place: the return consumes it
  // and the call refills the same slot, so pointer and count do not move.
  // call+ret on an empty stack degenerates to a plain push.
  always_comb begin
    w_replace = i_call && i_ret && w_ras_has;
    w_push    = i_call && !w_replace;
    w_pop     = i_ret && !i_call && w_ras_has;
    w_top_nxt = r_top;
    w_cnt_nxt = r_cnt;
    w_wr_idx  = w_replace ? r_top : w_top_inc;
    if (w_push) begin
      w_top_nxt = w_top_inc;
      // Saturate the count; the pointer still advances, so the oldest entry is lost.
      if (r_cnt != CNT_FULL) begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end else if (w_pop) begin
      w_top_nxt = w_top_dec;
      w_cnt_nxt = r_cnt - CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc           <= RESET_VECTOR;
      r_top          <= '0;
      r_cnt          <= '0;
      r_misaligned   <= 1'b0;
      r_ret_from_ras <= 1'b0;
    end else if (i_stall) begin
      r_misaligned   <= 1'b0;
      r_ret_from_ras <= 1'b0;
    end else begin
      r_pc           <= w_target & ~LOW_MASK;
      r_misaligned   <= |(w_target & LOW_MASK);
      r_ret_from_ras <= w_ras_used;
      r_top          <= w_top_nxt;
      r_cnt          <= w_cnt_nxt;
    end
  end

  // Stack storage carries no reset: entries are only read once the count
  // says they were written after the last reset.
  always_ff @(posedge i_clk) begin
    if (!i_stall && i_call) begin
      r_ras[w_wr_idx] <= w_pc_plus_step;
    end
  end

  assign o_pc           = r_pc;
  assign o_pc_plus_step = w_pc_plus_step;
  assign o_misaligned   = r_misaligned;
  assign o_ret_from_ras = r_ret_from_ras;
  assign o_ras_empty    = (r_cnt == '0);
  assign o_ras_full     = (r_cnt == CNT_FULL);

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall, br, jmp, call, jr, ret;
  logic [31:0] off, jt, rt;
  logic [31:0] pc, pps;
  logic        mis, rfr, empty, full;

  pc_unit #(.WIDTH(32), .STEP(4), .RESET_VECTOR(32'h0), .RAS_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall),
    .i_branch_taken(br), .i_branch_offset(off),
    .i_jump(jmp), .i_jump_target(jt),
    .i_call(call), .i_jr(jr), .i_ret(ret), .i_reg_target(rt),
    .o_pc(pc), .o_pc_plus_step(pps), .o_misaligned(mis),
    .o_ret_from_ras(rfr), .o_ras_empty(empty), .o_ras_full(full)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: PC as a plain number, RAS as a queue (back = newest).
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_mis, m_rfr;

  typedef struct {
    logic [5:0]  ctl;   // {stall, br, jmp, call, jr, ret}
    logic [31:0] off, jt, rt;
    logic [31:0] e_pc;
    logic [3:0]  fl;    // {misaligned, ret_from_ras, empty, full}
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(input logic [5:0] c, input logic [31:0] o, j, r, e,
                               input logic [3:0] f);
    vec_t v;
    v.ctl = c; v.off = o; v.jt = j; v.rt = r; v.e_pc = e; v.fl = f;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] c, input logic [31:0] o, j, r);
    {stall, br, jmp, call, jr, ret} = c;
    off = o; jt = j; rt = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input logic [3:0] f);
    chk({tag, ".misaligned"}, {31'b0, mis}, {31'b0, f[3]});
    chk({tag, ".ret_from_ras"}, {31'b0, rfr}, {31'b0, f[2]});
    chk({tag, ".ras_empty"}, {31'b0, empty}, {31'b0, f[1]});
    chk({tag, ".ras_full"}, {31'b0, full}, {31'b0, f[0]});
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ras.delete(); m_mis = 1'b0; m_rfr = 1'b0;
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step();
    logic [31:0] link, tgt;
    logic used;
    link = m_pc + 32'd4;
    if (stall) begin
      m_mis = 1'b0; m_rfr = 1'b0;
      return;
    end
    used = 1'b0;
    if (ret) begin
      if (m_ras.size() > 0) begin tgt = m_ras[m_ras.size()-1]; used = 1'b1; end
      else tgt = rt;
    end else if (jr)  tgt = rt;
    else if (jmp)     tgt = jt;
    else if (br)      tgt = link + off;
    else              tgt = link;
    if (call && ret && m_ras.size() > 0) m_ras[m_ras.size()-1] = link;
    else if (call) begin
      m_ras.push_back(link);
      if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
    end else if (ret && m_ras.size() > 0) void'(m_ras.pop_back());
    m_pc  = {tgt[31:2], 2'b00};
    m_mis = (tgt[1:0] != 2'b00);
    m_rfr = used;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".pc_plus_step"}, pps, m_pc + 32'd4);
    chk_flags(tag, {m_mis, m_rfr, m_ras.size() == 0, m_ras.size() == DEPTH});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(6'b0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.pc", pc, 32'h0);
    chk("reset.pc_plus_step", pps, 32'h4);
    chk_flags("reset", 4'b0010);
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [31:0] rnd_tgt();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 3) != 0) v[1:0] = 2'b00;
    return v;
  endfunction

  initial begin
    // ---------------- table-driven directed vectors ----------------
    tbl.push_back(mkv(6'b000000, 32'h0, 32'h0, 32'h0, 32'h4, 4'b0010));
    tbl.push_back(mkv(6'b000000, 32'h0, 32'h0, 32'h0, 32'h8, 4'b0010));
    tbl.push_back(mkv(6'b000000, 32'h0, 32'h0, 32'h0, 32'hC, 4'b0010));
    tbl.push_back(mkv(6'b000000, 32'h0, 32'h0, 32'h0, 32'h10, 4'b0010));
    tbl.push_back(mkv(6'b010000, 32'hFFFFFFF8, 32'h0, 32'h0, 32'hC, 4'b0010));
    tbl.push_back(mkv(6'b011000, 32'h0, 32'h100, 32'h0, 32'h100, 4'b0010));
    tbl.push_back(mkv(6'b001000, 32'h0, 32'h20, 32'h0, 32'h20, 4'b0010));
    tbl.push_back(mkv(6'b001100, 32'h0, 32'h200, 32'h0, 32'h200, 4'b0000));
    tbl.push_back(mkv(6'b000000, 32'h0, 32'h0, 32'h0, 32'h204, 4'b0000));
    tbl.push_back(mkv(6'b000001, 32'h0, 32'h0, 32'h0, 32'h24, 4'b0110));
    tbl.push_back(mkv(6'b000001, 32'h0, 32'h0, 32'h80, 32'h80, 4'b0010));
    tbl.push_back(mkv(6'b000010, 32'h0, 32'h0, 32'h1003, 32'h1000, 4'b1010));
    tbl.push_back(mkv(6'b111111, 32'h4, 32'h40, 32'h40, 32'h1000, 4'b0010));
    tbl.push_back(mkv(6'b111111, 32'h4, 32'h40, 32'h40, 32'h1000, 4'b0010));
    tbl.push_back(mkv(6'b111111, 32'h4, 32'h40, 32'h40, 32'h1000, 4'b0010));
    tbl.push_back(mkv(6'b000000, 32'h0, 32'h0, 32'h0, 32'h1004, 4'b0010));
    tbl.push_back(mkv(6'b000100, 32'h0, 32'h0, 32'h0, 32'h1008, 4'b0000));
    tbl.push_back(mkv(6'b000101, 32'h0, 32'h0, 32'h0, 32'h1008, 4'b0100));
    tbl.push_back(mkv(6'b000001, 32'h0, 32'h0, 32'h0, 32'h100C, 4'b0110));
    tbl.push_back(mkv(6'b000101, 32'h0, 32'h0, 32'h2000, 32'h2000, 4'b0000));
    tbl.push_back(mkv(6'b000001, 32'h0, 32'h0, 32'h0, 32'h1010, 4'b0110));
    tbl.push_back(mkv(6'b001000, 32'h0, 32'hFFFFFFFC, 32'h0, 32'hFFFFFFFC, 4'b0010));
    tbl.push_back(mkv(6'b000000, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0010));
    tbl.push_back(mkv(6'b011000, 32'h40, 32'h302, 32'h0, 32'h300, 4'b1010));
    tbl.push_back(mkv(6'b000000, 32'h0, 32'h0, 32'h0, 32'h304, 4'b0010));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(tbl[i].ctl, tbl[i].off, tbl[i].jt, tbl[i].rt);
      tick();
      chk({tag, ".pc"}, pc, tbl[i].e_pc);
      chk({tag, ".pc_plus_step"}, pps, tbl[i].e_pc + 32'd4);
      chk_flags(tag, tbl[i].fl);
    end

    // ---------------- RAS overflow ----------------
    do_reset();
    drive(6'b001000, 32'h0, 32'h100, 32'h0);
    tick();
    chk("ovf.start_pc", pc, 32'h100);
    for (int k = 1; k <= 5; k++) begin
      drive(6'b001100, 32'h0, 32'(k + 1) << 8, 32'h0);
      tick();
      chk($sformatf("ovf.call%0d.pc", k), pc, 32'(k + 1) << 8);
      chk($sformatf("ovf.call%0d.full", k), {31'b0, full}, {31'b0, k >= DEPTH});
    end
    for (int k = 0; k < 4; k++) begin
      drive(6'b000001, 32'h0, 32'h0, 32'hABC0);
      tick();
      chk($sformatf("ovf.ret%0d.pc", k), pc, 32'h504 - 32'(k << 8));
      chk($sformatf("ovf.ret%0d.rfr", k), {31'b0, rfr}, 32'd1);
    end
    chk("ovf.drained_empty", {31'b0, empty}, 32'd1);
    drive(6'b000001, 32'h0, 32'h0, 32'hABC0);
    tick();
    chk("ovf.ret_fallback.pc", pc, 32'hABC0);
    chk("ovf.ret_fallback.rfr", {31'b0, rfr}, 32'd0);

    // ---------------- asynchronous reset mid-cycle ----------------
    do_reset();
    drive(6'b000100, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    chk("arst.pre.pc", pc, 32'h8);
    chk("arst.pre.empty", {31'b0, empty}, 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst.now.pc", pc, 32'h0);
    chk("arst.now.empty", {31'b0, empty}, 32'd1);
    chk("arst.now.full", {31'b0, full}, 32'd0);
    drive(6'b0, 32'h0, 32'h0, 32'h0);
    tick();
    rst_n = 1'b1;
    drive(6'b000001, 32'h0, 32'h0, 32'h3C0);
    tick();
    chk("arst.ret.pc", pc, 32'h3C0);
    chk("arst.ret.rfr", {31'b0, rfr}, 32'd0);
    chk("arst.ret.empty", {31'b0, empty}, 32'd1);

    // ---------------- randomized against the model ----------------
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int ox;
      stall = ($urandom_range(0, 9) == 0);
      ret   = ($urandom_range(0, 6) == 0);
      jr    = ($urandom_range(0, 9) == 0);
      jmp   = ($urandom_range(0, 7) == 0);
      br    = ($urandom_range(0, 5) == 0);
      call  = ($urandom_range(0, 4) == 0);
      ox    = $urandom_range(0, 1023);
      off   = 32'(ox - 512);
      jt    = rnd_tgt();
      rt    = rnd_tgt();
      model_step();
      tick();
      chk_model($sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
